// File: rtl/fp32_stream_max_min_ctrl.sv
// Streaming FP32 max/min reduction controller driving an external pairwise comparator.
// Optional FP32_REDUCE_NAN_STICKY_EN: once the accumulator is NaN, remaining elements bypass the comparator.
module fp32_stream_max_min_ctrl #(
  parameter int unsigned CMP_LATENCY = 2,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_last,
  input  logic                 s_is_max,
  output logic                 cmp_valid,
  output logic                 cmp_is_max,
  output logic [31:0]          cmp_a,
  output logic [31:0]          cmp_b,
  input  logic                 cmp_res_valid,
  input  logic [31:0]          cmp_res,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic [LEN_WIDTH-1:0] m_count,
  output logic                 m_nan,
  output logic                 err
);

  typedef enum logic [2:0] {
    ST_FIRST,
    ST_NEXT,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 op_q, op_d;
  logic                 last_q, last_d;
  logic [1:0]           timer_q, timer_d;
  logic [31:0]          cmp_a_q, cmp_a_d;
  logic [31:0]          cmp_b_q, cmp_b_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_nan_q, m_nan_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 nan_skip;
  logic                 done;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    op_d     = op_q;
    last_d   = last_q;
    timer_d  = timer_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
    err_d    = err_q;
    done     = 1'b0;
    accept   = s_valid && s_ready_q;
`ifdef FP32_REDUCE_NAN_STICKY_EN
    nan_skip = (acc_q == '1);
`else
    nan_skip = 1'b0;
`endif

    case (state_q)
      ST_FIRST: begin
        if (accept) begin
          acc_d   = s_data;
          count_d = LEN_WIDTH'(1);
          op_d    = s_is_max;
          state_d = s_last ? ST_OUT : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (accept) begin
          count_d = (count_q == '1) ? count_q : count_q + LEN_WIDTH'(1);
          last_d  = s_last;
          if (nan_skip) begin
            state_d = s_last ? ST_OUT : ST_NEXT;
          end else begin
            // Operands are captured at accept so they hold steady until the next issue.
            cmp_a_d = acc_q;
            cmp_b_d = s_data;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = 2'(CMP_LATENCY);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmp_res_valid) begin
          acc_d = cmp_res;
          done  = 1'b1;
        end else if (timer_q <= 2'd1) begin
          acc_d = '1;
          err_d = 1'b1;
          done  = 1'b1;
        end else begin
          timer_d = timer_q - 2'd1;
        end
        if (done) state_d = last_q ? ST_OUT : ST_NEXT;
      end
      ST_OUT: begin
        if (m_ready) state_d = ST_FIRST;
      end
      default: state_d = ST_FIRST;
    endcase

    cmp_valid_d = (state_d == ST_ISSUE);
    s_ready_d   = (state_d == ST_FIRST) || (state_d == ST_NEXT);
    m_valid_d   = (state_d == ST_OUT);
    m_nan_d     = (acc_d == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      acc_q       <= '0;
      count_q     <= '0;
      op_q        <= 1'b0;
      last_q      <= 1'b0;
      timer_q     <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_valid_q <= 1'b0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_nan_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      op_q        <= op_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_valid_q <= cmp_valid_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_nan_q     <= m_nan_d;
      err_q       <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign cmp_valid  = cmp_valid_q;
  assign cmp_is_max = op_q;
  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign m_valid    = m_valid_q;
  assign m_data     = acc_q;
  assign m_count    = count_q;
  assign m_nan      = m_nan_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fp32_stream_max_min_ctrl.sv
// Scoreboard bench for fp32_stream_max_min_ctrl with a latency-2 comparator model.
module tb_fp32_stream_max_min_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_is_max = 1'b0;
  logic        cmp_valid;
  logic        cmp_is_max;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        cmp_res_valid = 1'b0;
  logic [31:0] cmp_res = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [15:0] m_count;
  logic        m_nan;
  logic        err;

  typedef struct {
    logic [31:0] d;
    logic [15:0] c;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  int   last_issue = 0;
  int   prev_issue = 0;
  logic cmp_drop = 1'b0;
  logic p_v = 1'b0;
  logic [31:0] p_d = '0;

  fp32_stream_max_min_ctrl #(.CMP_LATENCY(2), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_is_max(s_is_max),
    .cmp_valid(cmp_valid), .cmp_is_max(cmp_is_max), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_res_valid(cmp_res_valid), .cmp_res(cmp_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count), .m_nan(m_nan),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fp_sel(input logic [31:0] a, input logic [31:0] b, input logic mx);
    logic [31:0] ka, kb;
    if (is_nan(a) || is_nan(b)) return 32'hFFFF_FFFF;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    if (mx) return (kb > ka) ? b : a;
    return (kb < ka) ? b : a;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    return r;
  endfunction

  // Comparator model: result visible CMP_LATENCY cycles after the issue cycle; not reset by rst.
  always @(posedge clk) begin
    p_v           <= cmp_valid && !cmp_drop;
    p_d           <= fp_sel(cmp_a, cmp_b, cmp_is_max);
    cmp_res_valid <= p_v;
    cmp_res       <= p_d;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmp_valid) begin
      issue_cnt  <= issue_cnt + 1;
      prev_issue <= last_issue;
      last_issue <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic mx, output int acc_cyc);
    int n = 0;
    s_data = d; s_last = last; s_is_max = mx; s_valid = 1'b1;
    while (!s_ready && n < 200) begin tick(); n++; end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_wait s_ready=%b required=1", s_ready);
    end
    acc_cyc = cyc;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic collect(input string name);
    int n = 0;
    exp_t e;
    while (!m_valid && n < 200) begin tick(); n++; end
    total++;
    if (m_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_m_valid got=%b required=1", name, m_valid);
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_unexpected got=%h required=none", name, m_data);
      tick();
      return;
    end
    e = sb.pop_front();
    total++;
    if (m_data !== e.d) begin bad++; $display("FAIL %s_data got=%h required=%h", name, m_data, e.d); end
    total++;
    if (m_count !== e.c) begin bad++; $display("FAIL %s_count got=%0d required=%0d", name, m_count, e.c); end
    total++;
    if (m_nan !== e.n) begin bad++; $display("FAIL %s_nan got=%b required=%b", name, m_nan, e.n); end
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({s_ready, cmp_valid, cmp_is_max, m_valid, m_nan, err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=100000", {s_ready, cmp_valid, cmp_is_max, m_valid, m_nan, err});
    end
    total++;
    if ({cmp_a, cmp_b, m_data, m_count} !== '0) begin
      bad++;
      $display("FAIL reset_data got a=%h b=%h d=%h c=%0d required=0", cmp_a, cmp_b, m_data, m_count);
    end
  endtask

  task automatic test_max();
    int i0, t;
    i0 = issue_cnt;
    sb.push_back('{d: 32'h4040_0000, c: 16'd3, n: 1'b0});
    send(32'h3F80_0000, 1'b0, 1'b1, t);
    send(32'hC000_0000, 1'b0, 1'b0, t);
    send(32'h4040_0000, 1'b1, 1'b0, t);
    collect("max");
    total++;
    if (issue_cnt - i0 != 2) begin bad++; $display("FAIL max_issues got=%0d required=2", issue_cnt - i0); end
    total++;
    if (last_issue - prev_issue != 4) begin
      bad++; $display("FAIL max_spacing got=%0d required=4", last_issue - prev_issue);
    end
  endtask

  task automatic test_single();
    int i0, t;
    i0 = issue_cnt;
    sb.push_back('{d: 32'h7FC0_0001, c: 16'd1, n: 1'b0});
    send(32'h7FC0_0001, 1'b1, 1'b1, t);
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("FAIL single_latency m_valid=%b required=1", m_valid); end
    collect("single");
    total++;
    if (issue_cnt != i0) begin bad++; $display("FAIL single_issues got=%0d required=0", issue_cnt - i0); end
  endtask

  task automatic test_backpressure();
    int n = 0, t;
    exp_t e;
    e = '{d: 32'h3F80_0000, c: 16'd2, n: 1'b0};
    m_ready = 1'b0;
    send(32'h4000_0000, 1'b0, 1'b0, t);
    send(32'h3F80_0000, 1'b1, 1'b1, t);
    while (!m_valid && n < 200) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== e.d || m_count !== e.c) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b r=%b d=%h c=%0d required v=1 r=0 d=%h c=%0d",
                 i, m_valid, s_ready, m_data, m_count, e.d, e.c);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got r=%b v=%b required r=1 v=0", s_ready, m_valid);
    end
  endtask

  task automatic test_timeout();
    int t;
    sb.push_back('{d: 32'hFFFF_FFFF, c: 16'd3, n: 1'b1});
    send(32'h4000_0000, 1'b0, 1'b1, t);
    cmp_drop = 1'b1;
    send(32'h4040_0000, 1'b0, 1'b1, t);
    tick();
    cmp_drop = 1'b0;
    send(32'h3F80_0000, 1'b1, 1'b1, t);
    collect("timeout");
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b required=1", err); end
  endtask

  task automatic test_nan();
    int a[6];
    int i0;
    logic [31:0] v[6];
    v = '{32'h4000_0000, 32'h7FC0_0000, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 32'h4080_0000};
    i0 = issue_cnt;
    sb.push_back('{d: 32'hFFFF_FFFF, c: 16'd6, n: 1'b1});
    for (int k = 0; k < 6; k++) send(v[k], (k == 5), 1'b1, a[k]);
    collect("nan");
`ifdef FP32_REDUCE_NAN_STICKY_EN
    for (int k = 3; k < 6; k++) begin
      total++;
      if (a[k] - a[k-1] != 1) begin bad++; $display("FAIL nan_gap%0d got=%0d required=1", k, a[k] - a[k-1]); end
    end
    total++;
    if (issue_cnt - i0 != 1) begin bad++; $display("FAIL nan_issues got=%0d required=1", issue_cnt - i0); end
`else
    for (int k = 3; k < 6; k++) begin
      total++;
      if (a[k] - a[k-1] != 4) begin bad++; $display("FAIL nan_gap%0d got=%0d required=4", k, a[k] - a[k-1]); end
    end
    total++;
    if (issue_cnt - i0 != 5) begin bad++; $display("FAIL nan_issues got=%0d required=5", issue_cnt - i0); end
`endif
  endtask

  task automatic test_back_to_back();
    int len, t;
    logic op;
    logic [31:0] acc, e;
    logic [31:0] d[5];
    for (int v = 0; v < 6; v++) begin
      len = $urandom_range(1, 5);
      op  = 1'($urandom_range(0, 1));
      acc = '0;
      for (int k = 0; k < len; k++) begin
        e = rand_fp();
        d[k] = e;
        acc = (k == 0) ? e : fp_sel(acc, e, op);
      end
      sb.push_back('{d: acc, c: 16'(len), n: (acc == 32'hFFFF_FFFF)});
      for (int k = 0; k < len; k++)
        send(d[k], (k == len - 1), (k == 0) ? op : 1'($urandom_range(0, 1)), t);
      collect("b2b");
    end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required=1", err); end
  endtask

  task automatic test_reset_mid();
    int t;
    send(32'h4000_0000, 1'b0, 1'b1, t);
    send(32'h4040_0000, 1'b0, 1'b1, t);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    tick();
    tick();
    total++;
    if (m_valid !== 1'b0 || err !== 1'b0 || m_data !== 32'd0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_late got v=%b e=%b d=%h r=%b required v=0 e=0 d=0 r=1", m_valid, err, m_data, s_ready);
    end
  endtask

  initial begin
    tick(); tick(); tick();
    rst = 1'b0;
    test_reset();
    test_max();
    test_single();
    test_backpressure();
    test_timeout();
    test_nan();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
